keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver.
- The display driver scans digit selects out and drives segments. This block scans the rows of a 4x4 key matrix and reads the columns back.
- It debounces the result and emits clean single-cycle press and release events with a key code, for the counter/control logic.
- It replaces raw button edges used as clocks. Everything runs on the 1 kHz system clock.

Parameters:
- ROWS, 4, number of matrix rows (driven outputs).
- COLS, 4, number of matrix columns (sampled inputs).
- ROW_CYC, 4, clock cycles each row is driven; must be >= 3.
- DEB_SCANS, 4, consecutive identical full-scan results required to accept a press or release; must be >= 2.
- KEY_W, $clog2(ROWS*COLS), key code width (4 at defaults).

Ports:
- clk  in  1  system clock, 1 kHz.
- rst  in  1  reset: synchronous, active-high.
- row_n  out  ROWS  row drive, active-low, one-hot-low while scanning.
- col_n  in  COLS  column sense, active-low (pull-ups), asynchronous to clk.
- key_code  out  KEY_W  last accepted key = row*COLS + col.
- key_valid  out  1  one-cycle pulse when a press is accepted.
- key_held  out  1  high while the accepted key is considered held.
- key_release  out  1  one-cycle pulse when a release is accepted.

Behaviour:
- Reset (rst high at a clk edge):
  - row_n = all ones; key_code = 0; key_valid, key_held, key_release = 0.
  - Synchronizer flops = all ones; row index = 0, cycle count = 0; FSM = IDLE; candidate and debounce count = 0.
  - Reset mid-press or mid-debounce discards the event; no pulse is emitted.
- Column sync: col_n passes through two flops before use. Sampled value = inverted synchronized column bits.
- Scan timing:
  - Row r is driven low for ROW_CYC cycles, starting the first cycle after reset release at row 0. Rows then go 0,1,...,ROWS-1 and wrap.
  - Columns for row r are sampled on cycle ROW_CYC-1 of that row's window. Sync latency of 2 cycles is therefore inside the window.
  - Full scan period = ROWS*ROW_CYC cycles (16 at defaults).
- Scan result, formed after the last row's sample:
  - NONE: zero bits set.
  - SINGLE(c): exactly one bit set; c = row*COLS + col.
  - MULTI: two or more bits set, including ghosting.
- FSM evaluation: the FSM steps once per scan, on the cycle after the final row sample (scan_done). All output changes are registered on that edge.
- FSM states:
  - IDLE:
    - SINGLE(c) -> cand = c, cnt = 1, go to PRESS_WAIT.
    - Otherwise stay.
  - PRESS_WAIT:
    - SINGLE(cand) -> cnt + 1. When cnt reaches DEB_SCANS: key_code = cand, key_valid pulse, key_held = 1, go to HELD.
    - SINGLE(c != cand) -> cand = c, cnt = 1.
    - NONE or MULTI -> go to IDLE.
  - HELD:
    - NONE -> cnt = 1, go to RELEASE_WAIT.
    - SINGLE (any code) or MULTI -> stay. No new press is reported until release.
  - RELEASE_WAIT:
    - NONE -> cnt + 1. When cnt reaches DEB_SCANS: key_release pulse, key_held = 0, go to IDLE.
    - Anything else -> go to HELD (bounce absorbed, no pulse).
- Pulse and hold rules:
  - key_valid and key_release are exactly one cycle wide.
  - They are never asserted in the same cycle.
  - key_code is stable from key_valid until the next key_valid; it is not cleared on release.
- Latency: a press that is stable from before a scan starts gives key_valid DEB_SCANS scans later, +1 cycle after that scan's last sample.
- Counters: cnt saturates at DEB_SCANS. The row index wraps ROWS-1 -> 0. The cycle counter wraps ROW_CYC-1 -> 0.

Decomposition:
- keypad_pkg:
  - FSM state enum (IDLE, PRESS_WAIT, HELD, RELEASE_WAIT).
  - Scan-result enum (NONE, SINGLE, MULTI).
  - Default ROWS/COLS/ROW_CYC/DEB_SCANS constants.
  - One-hot-to-index helper function.
- One sub-module: sync2, a parameterised-width two-flop synchronizer with reset value all-ones, used for col_n.

Test Plan:
- Reset then idle, col_n = 4'b1111 held: row_n cycles 1110,1101,1011,0111, each for 4 cycles. Period is 16. No key_valid or key_release ever.
- Key row1/col2 pressed cleanly (col_n[2] low only while row_n = 1101), held 200 cycles:
  - Exactly one key_valid with key_code = 6, after 4 scans (<= 64+16 cycles from press).
  - key_held = 1 until release.
  - After release, one key_release 4 scans later.
- Press key 6 with 3-scan bounce toggling (stable only 2 scans each time), then stable: no key_valid during bounce; single key_valid, code 6, only after 4 consecutive stable scans.
- Keys 0 and 5 pressed together from IDLE: no key_valid (MULTI). Release key 5, leaving key 0: key_valid with code 0 after 4 scans.
- Key 15 held, released for 2 scans, re-pressed: no key_release and no second key_valid. key_held stays 1.
- rst pulsed for 1 cycle during PRESS_WAIT (cnt = 3): no key_valid. row_n = 1111 in the reset cycle, row 0 driven the next cycle. Debounce restarts from scratch.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, defaults and helpers for the keypad scanner
// Purpose: FSM and scan-result enums, default matrix geometry and timing,
//          and a one-hot-to-index helper used when decoding a column hit.
// Ports:   none (package).
package keypad_pkg;

  localparam int DEF_ROWS      = 4;
  localparam int DEF_COLS      = 4;
  localparam int DEF_ROW_CYC   = 4;
  localparam int DEF_DEB_SCANS = 4;

  // Widest one-hot vector the helper accepts; column counts stay well below it.
  localparam int OH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_res_e;

  // Index of the set bit in a one-hot vector; callers only use it when
  // exactly one bit is set.
  function automatic int onehot_to_idx(input logic [OH_MAX-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < OH_MAX; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// rtl/keypad_scanner_sync2.sv - two-flop synchronizer, resets to all ones
// Purpose: bring the asynchronous active-low column lines into the clk domain.
//          Resetting to all ones means "no key" while the chain refills.
// Ports:   clk, rst (sync, active-high), d (async input), q (synchronized).
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 key matrix scanner with debounced press/release events
// Purpose: drives one row low at a time, samples the columns late in each row
//          window, classifies every full scan as NONE/SINGLE/MULTI and debounces
//          the result into single-cycle press and release events.
// Ports:   clk, rst (sync, active-high); row_n (row drive, active-low);
//          col_n (column sense, active-low, async); key_code (last accepted key,
//          row*COLS+col); key_valid / key_release (one-cycle events);
//          key_held (accepted key still down).
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS      = DEF_ROWS,
  parameter int COLS      = DEF_COLS,
  parameter int ROW_CYC   = DEF_ROW_CYC,
  parameter int DEB_SCANS = DEF_DEB_SCANS,
  parameter int KEY_W     = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [ROWS-1:0]  row_n,
  input  logic [COLS-1:0]  col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             key_release
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (ROW_CYC > 1) ? $clog2(ROW_CYC) : 1;
  localparam int NW = $clog2(DEB_SCANS + 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(ROW_CYC - 1);
  localparam logic [NW-1:0] DEB_MAX  = NW'(DEB_SCANS);

  // ---------------- row scan timing ----------------
  logic             run;
  logic [RW-1:0]    row_idx, row_idx_d;
  logic [CW-1:0]    cyc;
  logic             sample_en;
  logic [COLS-1:0]  col_s;

  sync2 #(.WIDTH(COLS)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_n),
    .q   (col_s)
  );

  // Sampling on the last cycle of a row window leaves the two-flop sync
  // latency inside the window that row is driven.
  assign sample_en = run && (cyc == LAST_CYC);

  always_comb begin
    row_idx_d = row_idx;
    if (sample_en) row_idx_d = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
  end

  // run holds the counters for the one idle cycle after reset so row 0 gets
  // a full window starting the first cycle after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      run     <= 1'b0;
      row_idx <= '0;
      cyc     <= '0;
      row_n   <= '1;
    end else begin
      run <= 1'b1;
      if (run) begin
        cyc     <= sample_en ? '0 : cyc + 1'b1;
        row_idx <= row_idx_d;
      end
      row_n <= ~(ROWS'(1) << row_idx_d);
    end
  end

  // ---------------- scan accumulation ----------------
  // acc_n counts hits seen so far in this scan: 0, 1, or 2 meaning "many".
  logic [COLS-1:0]  hits;
  logic [1:0]       acc_n, base_n, merge_n;
  logic [KEY_W-1:0] acc_code, base_code, merge_code;
  logic             scan_done;
  scan_res_e        scan_res;
  logic [KEY_W-1:0] scan_code;

  always_comb begin
    hits       = ~col_s;
    base_n     = (row_idx == '0) ? 2'd0 : acc_n;
    base_code  = (row_idx == '0) ? '0 : acc_code;
    merge_n    = base_n;
    merge_code = base_code;
    if ($countones(hits) > 1) begin
      merge_n = 2'd2;
    end else if ($countones(hits) == 1) begin
      merge_n    = (base_n == 2'd0) ? 2'd1 : 2'd2;
      merge_code = KEY_W'(int'(row_idx) * COLS + onehot_to_idx(OH_MAX'(hits)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_n     <= '0;
      acc_code  <= '0;
      scan_done <= 1'b0;
      scan_res  <= NONE;
      scan_code <= '0;
    end else begin
      scan_done <= sample_en && (row_idx == LAST_ROW);
      if (sample_en) begin
        acc_n    <= merge_n;
        acc_code <= merge_code;
        if (row_idx == LAST_ROW) begin
          scan_res  <= (merge_n == 2'd0) ? NONE : ((merge_n == 2'd1) ? SINGLE : MULTI);
          scan_code <= merge_code;
        end
      end
    end
  end

  // ---------------- debounce FSM ----------------
  kp_state_e        state, state_d;
  logic [KEY_W-1:0] cand, cand_d, code_d;
  logic [NW-1:0]    cnt, cnt_d;
  logic             valid_d, release_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_d;
      cand        <= cand_d;
      cnt         <= cnt_d;
      key_code    <= code_d;
      key_valid   <= valid_d;
      key_release <= release_d;
    end
  end

  always_comb begin
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (scan_res == SINGLE) begin
            cand_d  = scan_code;
            cnt_d   = NW'(1);
            state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (scan_res == SINGLE && scan_code == cand) begin
            cnt_d = (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
            if (cnt_d == DEB_MAX) state_d = HELD;
          end else if (scan_res == SINGLE) begin
            cand_d = scan_code;
            cnt_d  = NW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (scan_res == NONE) begin
            cnt_d   = NW'(1);
            state_d = RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (scan_res == NONE) begin
            cnt_d = (cnt == DEB_MAX) ? cnt : cnt + 1'b1;
            if (cnt_d == DEB_MAX) state_d = IDLE;
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Events are decoded from the transition so each lasts exactly one cycle;
  // the two transitions come from different states, so they never coincide.
  always_comb begin
    valid_d   = (state == PRESS_WAIT) && (state_d == HELD);
    release_d = (state == RELEASE_WAIT) && (state_d == IDLE);
    code_d    = valid_d ? cand : key_code;
    key_held  = (state == HELD) || (state == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed and randomized check of keypad_scanner against a scan-level model
module tb_keypad_scanner;

  localparam int DEB  = 4;
  localparam int SCAN = 16;
  localparam int EVAL = 17;

  logic       clk;
  logic       rst;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic       key_release;

  keypad_scanner dut (
    .clk         (clk),
    .rst         (rst),
    .row_n       (row_n),
    .col_n       (col_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_held    (key_held),
    .key_release (key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key matrix: a column reads low when any pressed key on a driven row is on it.
  logic [15:0] keys;
  always_comb begin
    col_n = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
  end

  // ---------------- scan-level model ----------------
  int          t;
  logic [3:0]  exp_row;
  logic        exp_valid, exp_release, exp_held;
  logic [3:0]  exp_code;
  bit          m_held;
  int          m_code;
  int          hist[$];
  int          pending[$];
  logic [15:0] plan[$];
  bit          chk_en;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int n_release = 0;
  int last_valid_t = -1;
  int last_release_t = -1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0d: got %0d expected %0d", name, t, act, exp);
    end
  endtask

  // -1 = no key, -2 = several keys, otherwise the key number.
  function automatic int classify(input logic [15:0] k);
    if (k == 16'h0) return -1;
    if ($countones(k) > 1) return -2;
    for (int i = 0; i < 16; i++) if (k[i]) return i;
    return -1;
  endfunction

  // A press is accepted once the last DEB scans all saw the same single key;
  // a release once the last DEB scans all saw nothing.
  task automatic evaluate();
    int r;
    bit same;
    r = pending.pop_front();
    hist.push_back(r);
    if (hist.size() < DEB) return;
    same = 1'b1;
    for (int i = hist.size() - DEB; i < hist.size(); i++) if (hist[i] != r) same = 1'b0;
    if (!same) return;
    if (!m_held && r >= 0) begin
      exp_valid = 1'b1;
      m_held    = 1'b1;
      m_code    = r;
    end else if (m_held && r == -1) begin
      exp_release = 1'b1;
      m_held      = 1'b0;
    end
  endtask

  task automatic tick();
    logic was_rst;
    was_rst = rst;
    @(posedge clk);
    #1;
    exp_valid   = 1'b0;
    exp_release = 1'b0;
    if (was_rst) begin
      t       = -1;
      m_held  = 1'b0;
      m_code  = 0;
      hist.delete();
      pending.delete();
      exp_row = 4'hF;
    end else begin
      t++;
      exp_row = ~(4'b0001 << ((t / 4) % 4));
      if (t % SCAN == 0) begin
        keys = (plan.size() > 0) ? plan.pop_front() : 16'h0;
        pending.push_back(classify(keys));
      end
      if (t >= EVAL && (t - EVAL) % SCAN == 0) evaluate();
    end
    exp_held = m_held;
    exp_code = 4'(m_code);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_n(input logic [15:0] k, input int n);
    repeat (n) plan.push_back(k);
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("row_n", int'(row_n), int'(exp_row));
      check("key_valid", int'(key_valid), int'(exp_valid));
      check("key_release", int'(key_release), int'(exp_release));
      check("key_held", int'(key_held), int'(exp_held));
      check("key_code", int'(key_code), int'(exp_code));
      check("pulse_overlap", int'(key_valid & key_release), 0);
      if (key_valid) begin
        n_valid++;
        last_valid_t = t;
      end
      if (key_release) begin
        n_release++;
        last_release_t = t;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0, r0, sel, len, a, b;
    logic [15:0] k;
    rst    = 1'b1;
    keys   = 16'h0;
    chk_en = 1'b0;
    t      = -1;
    tick();
    rst    = 1'b0;
    chk_en = 1'b1;
    check("reset_row_n", int'(row_n), 15);
    check("reset_key_held", int'(key_held), 0);

    // Idle: rows rotate, no events.
    v0 = n_valid; r0 = n_release;
    do_reset();
    tick();
    check("first_row_n", int'(row_n), 14);
    run(4 * SCAN + EVAL);
    check("idle_valid_cnt", n_valid - v0, 0);
    check("idle_release_cnt", n_release - r0, 0);

    // Clean press of key 6, held 13 scans, then released.
    plan.delete();
    do_reset();
    v0 = n_valid; r0 = n_release;
    push_n(16'h0040, 13);
    run(20 * SCAN + EVAL + 1);
    check("k6_valid_cnt", n_valid - v0, 1);
    check("k6_valid_t", last_valid_t, 65);
    check("k6_code", int'(key_code), 6);
    check("k6_release_cnt", n_release - r0, 1);
    check("k6_release_t", last_release_t, 273);

    // Bouncing key 6: two-scan bursts before it settles.
    plan.delete();
    do_reset();
    v0 = n_valid;
    for (int i = 0; i < 3; i++) begin
      push_n(16'h0040, 2);
      push_n(16'h0000, 1);
    end
    push_n(16'h0040, 5);
    run(20 * SCAN + EVAL + 1);
    check("bounce_valid_cnt", n_valid - v0, 1);
    check("bounce_valid_t", last_valid_t, 209);
    check("bounce_code", int'(key_code), 6);

    // Keys 0 and 5 together, then key 0 alone.
    plan.delete();
    do_reset();
    v0 = n_valid; r0 = n_release;
    push_n(16'h0021, 5);
    push_n(16'h0001, 6);
    run(18 * SCAN + EVAL + 1);
    check("multi_valid_cnt", n_valid - v0, 1);
    check("multi_valid_t", last_valid_t, 145);
    check("multi_release_cnt", n_release - r0, 1);

    // Key 15 with a two-scan gap: absorbed, no release.
    plan.delete();
    do_reset();
    v0 = n_valid; r0 = n_release;
    push_n(16'h8000, 6);
    push_n(16'h0000, 2);
    push_n(16'h8000, 6);
    run(14 * SCAN + EVAL + 1);
    check("gap_valid_cnt", n_valid - v0, 1);
    check("gap_release_cnt", n_release - r0, 0);
    check("gap_held", int'(key_held), 1);
    check("gap_code", int'(key_code), 15);

    // Reset in the middle of a press debounce.
    plan.delete();
    do_reset();
    v0 = n_valid;
    push_n(16'h0040, 20);
    run(53);
    check("midrst_no_valid", n_valid - v0, 0);
    do_reset();
    check("midrst_row_n", int'(row_n), 15);
    tick();
    check("midrst_row0", int'(row_n), 14);
    run(70);
    check("midrst_valid_cnt", n_valid - v0, 1);
    check("midrst_valid_t", last_valid_t, 65);

    // Randomized runs of no key, single keys and key pairs.
    plan.delete();
    do_reset();
    while (plan.size() < 80) begin
      sel = $urandom_range(0, 3);
      len = $urandom_range(1, 6);
      a   = $urandom_range(0, 15);
      b   = $urandom_range(0, 15);
      case (sel)
        0:       k = 16'h0;
        1, 2:    k = 16'h0001 << a;
        default: k = (16'h0001 << a) | (16'h0001 << b);
      endcase
      push_n(k, len);
    end
    run((plan.size() + 6) * SCAN + EVAL + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
